// File: rtl/multi_debouncer_pkg.sv
// multi_debouncer_pkg
// Shared defaults and the counter-width derivation for the multi-channel
// debouncer. Imported by debounce_channel and multi_debouncer.
// Optional feature macro (used in debounce_channel): MULTI_DEBOUNCER_SYNC_EN
package multi_debouncer_pkg;

  localparam int DEFAULT_NUM_CH        = 4;
  localparam int DEFAULT_STABLE_CYCLES = 8;

  // The counter must be able to hold the value STABLE_CYCLES itself for the
  // moment it is compared, even though it never rests there.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One debounced input: optional two-flop synchronizer, qualification
// counter, registered level and registered rise/fall pulses.
// Build option: MULTI_DEBOUNCER_SYNC_EN adds a two-flop synchronizer in
// front of the comparator (adds two cycles of latency).
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   sample_en - sampling qualifier; counter and level hold while low
//   in        - raw input level
//   out       - debounced level
//   rise/fall - one-cycle pulses coinciding with out's new value
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);

  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

`ifdef MULTI_DEBOUNCER_SYNC_EN
  logic sync1;
  logic sync2;

  // The synchronizer runs every cycle, independent of sample_en, so the
  // qualifier only gates the decision logic, never metastability settling.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = in;
`endif

  assign cnt_inc = cnt + CW'(1);

  // Any sample that agrees with the current level restarts qualification;
  // reaching TARGET disagreeing samples flips the level and emits a pulse
  // in the same cycle the new level appears. Reset clears the level
  // without producing a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_en) begin
        if (s != out) begin
          if (cnt_inc == TARGET) begin
            cnt  <= '0;
            out  <= ~out;
            rise <= ~out;
            fall <= out;
          end else begin
            cnt <= cnt_inc;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer
// NUM_CH independent debouncers sharing a clock, reset and sample qualifier.
// Build option: MULTI_DEBOUNCER_SYNC_EN (handled per channel) inserts a
// two-flop synchronizer on every input.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   sample_en - sampling qualifier, tie high to sample every cycle
//   in        - raw per-channel inputs
//   out       - debounced levels (registered)
//   rise      - per-channel 0->1 pulses (registered)
//   fall      - per-channel 1->0 pulses (registered)
//   any_edge  - OR of all rise and fall bits
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int NUM_CH        = DEFAULT_NUM_CH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_edge
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .in       (in[i]),
      .out      (out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  // Pulses are already registered, so this summary lands in the same cycle.
  assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer
// Directed self-checking bench for multi_debouncer with NUM_CH=4,
// STABLE_CYCLES=8. Works with or without MULTI_DEBOUNCER_SYNC_EN defined.
module tb_multi_debouncer;

  localparam int NUM_CH = 4;
  localparam int STABLE = 8;
`ifdef MULTI_DEBOUNCER_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = STABLE + EXTRA;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_en;
  logic [NUM_CH-1:0] in;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              any_edge;

  int checks = 0;
  int errors = 0;

  multi_debouncer #(
    .NUM_CH(NUM_CH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .in       (in),
    .out      (out),
    .rise     (rise),
    .fall     (fall),
    .any_edge (any_edge)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with active inputs must leave everything cleared.
  task automatic test_reset();
    reset = 1'b1;
    sample_en = 1'b1;
    in = 4'b1111;
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || any_edge !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: out=%b rise=%b fall=%b any=%b, required 0000/0000/0000/0", out, rise, fall, any_edge);
    end
    in = 4'b0000;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (out !== 4'b0000 || any_edge !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: out=%b any=%b, required 0000/0", out, any_edge);
    end
  endtask

  // Channel 0 goes high and stays high: level flips after exactly LAT edges.
  task automatic test_single_rise();
    in = 4'b0001;
    for (int n = 1; n <= LAT + 1; n++) begin
      logic [3:0] exp_out;
      logic [3:0] exp_rise;
      step();
      exp_out  = (n >= LAT) ? 4'b0001 : 4'b0000;
      exp_rise = (n == LAT) ? 4'b0001 : 4'b0000;
      checks++;
      if (out !== exp_out || rise !== exp_rise || fall !== 4'b0000 || any_edge !== (n == LAT)) begin
        errors++;
        $display("[TB] FAIL single_rise edge %0d: out=%b rise=%b fall=%b any=%b, required %b/%b/0000/%b",
                 n, out, rise, fall, any_edge, exp_out, exp_rise, (n == LAT));
      end
    end
  endtask

  // Channel 1: 7 high, 1 low glitch, then 8 high -> one rise after edge 16.
  task automatic test_glitch();
    int pulses = 0;
    int target = 16 + EXTRA;
    for (int n = 1; n <= target + 3; n++) begin
      logic [3:0] exp_out;
      logic [3:0] exp_rise;
      in = (n == 8) ? 4'b0001 : 4'b0011;
      step();
      if (rise[1] === 1'b1) pulses++;
      exp_out  = (n >= target) ? 4'b0011 : 4'b0001;
      exp_rise = (n == target) ? 4'b0010 : 4'b0000;
      checks++;
      if (out !== exp_out || rise !== exp_rise) begin
        errors++;
        $display("[TB] FAIL glitch edge %0d: out=%b rise=%b, required %b/%b", n, out, rise, exp_out, exp_rise);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL glitch_pulse_count: got %0d, required 1", pulses);
    end
  endtask

  // Channel 2 with sampling every 4th edge: flips on the 8th qualified edge.
  task automatic test_sample_en();
    in = 4'b0111;
    for (int n = 1; n <= 40; n++) begin
      logic [3:0] exp_out;
      logic [3:0] exp_rise;
      sample_en = (n % 4 == 0);
      step();
      exp_out  = (n >= 32) ? 4'b0111 : 4'b0011;
      exp_rise = (n == 32) ? 4'b0100 : 4'b0000;
      checks++;
      if (out !== exp_out || rise !== exp_rise || fall !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL sample_en edge %0d: out=%b rise=%b fall=%b, required %b/%b/0000",
                 n, out, rise, fall, exp_out, exp_rise);
      end
    end
    sample_en = 1'b1;
  endtask

  // All channels fall together; then a reset mid-qualification.
  task automatic test_all_fall_and_reset();
    in = 4'b1111;
    for (int n = 0; n < LAT + 2; n++) step();
    checks++;
    if (out !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL settle_high: out=%b, required 1111", out);
    end
    in = 4'b0000;
    for (int n = 1; n <= LAT + 1; n++) begin
      logic [3:0] exp_out;
      logic [3:0] exp_fall;
      step();
      exp_out  = (n >= LAT) ? 4'b0000 : 4'b1111;
      exp_fall = (n == LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (out !== exp_out || fall !== exp_fall || rise !== 4'b0000 || any_edge !== (n == LAT)) begin
        errors++;
        $display("[TB] FAIL all_fall edge %0d: out=%b fall=%b rise=%b any=%b, required %b/%b/0000/%b",
                 n, out, fall, rise, any_edge, exp_out, exp_fall, (n == LAT));
      end
    end
    // Repeat, with reset landing on edge 5 of the falling qualification.
    in = 4'b1111;
    for (int n = 0; n < LAT + 2; n++) step();
    in = 4'b0000;
    for (int n = 0; n < 4; n++) step();
    reset = 1'b1;
    step();
    checks++;
    if (out !== 4'b0000 || fall !== 4'b0000 || rise !== 4'b0000 || any_edge !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_qual: out=%b fall=%b rise=%b any=%b, required 0000/0000/0000/0", out, fall, rise, any_edge);
    end
    reset = 1'b0;
    // Leftover counts would make this rise arrive early.
    in = 4'b1111;
    for (int n = 1; n <= LAT; n++) begin
      logic [3:0] exp_out;
      step();
      exp_out = (n >= LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (out !== exp_out || rise !== exp_out) begin
        errors++;
        $display("[TB] FAIL post_reset_rise edge %0d: out=%b rise=%b, required %b/%b", n, out, rise, exp_out, exp_out);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sample_en = 1'b0;
    in = '0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_sample_en();
    test_all_fall_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
